// File: rtl/add_serial_nbit.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, STEP bits per clock.
// Optional subtract mode (a - b as a + ~b + 1) is enabled by defining ADD_SERIAL_SUB_EN.

module add_serial_digit #(
   parameter int STEP = 1
) (
   input  logic [STEP-1:0] a_dig,
   input  logic [STEP-1:0] b_dig,
   input  logic            cin,
   output logic [STEP-1:0] sum,
   output logic            cout,
   output logic            c_msb
);
   always_comb begin
      {cout, sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{STEP{1'b0}}, cin};
      // Carry into the digit's top bit recovered from the sum bit itself.
      c_msb = sum[STEP-1] ^ a_dig[STEP-1] ^ b_dig[STEP-1];
   end
endmodule

module add_serial_nbit #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADD_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int STEP_C = (STEP < 1) ? 1 : STEP;
   localparam int N      = WIDTH / STEP_C;
   localparam int CW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP_C) != 0) begin : g_bad_step
      $error("add_serial_nbit: STEP (%0d) must divide WIDTH (%0d)", STEP, WIDTH);
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0]  b_in;
   logic              c_in;
   logic [STEP_C-1:0] dig_sum;
   logic              dig_cout;
   logic              dig_cmsb;

   // Operand conditioning at capture time so the datapath only ever adds.
   always_comb begin
      b_in = b;
      c_in = cin;
`ifdef ADD_SERIAL_SUB_EN
      if (sub) begin
         b_in = ~b;
         c_in = 1'b1;
      end
`endif
   end

   add_serial_digit #(.STEP(STEP_C)) u_digit (
      .a_dig (a_sr_q[STEP_C-1:0]),
      .b_dig (b_sr_q[STEP_C-1:0]),
      .cin   (carry_q),
      .sum   (dig_sum),
      .cout  (dig_cout),
      .c_msb (dig_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b_in;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sr_d  = a_sr_q >> STEP_C;
            b_sr_d  = b_sr_q >> STEP_C;
            carry_d = dig_cout;
            res_d[int'(cnt_q) * STEP_C +: STEP_C] = dig_sum;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               s_d     = res_d;
               cout_d  = dig_cout;
               ovf_d   = dig_cout ^ dig_cmsb;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: doc/add_serial_nbit.md
Name: add_serial_nbit

Overview:
- Parametrised bit-serial / digit-serial adder; successor to the single-bit full adder cell.
- Adds two WIDTH-bit operands plus carry-in, STEP bits per clock, using one carry register.
- Start/busy/done handshake; the result is registered and held until the next completion.
- Used wherever area matters more than latency, e.g. accumulation in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits.
- STEP, 1, bits added per clock. Must divide WIDTH; an illegal value stops elaboration with $error.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: s, cout and ovf are newly valid.
- s  output  WIDTH  sum, registered.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Let N = WIDTH/STEP.
- FSM states: IDLE, RUN, DONE.
- Reset:
  - rst_n low forces state=IDLE immediately (asynchronously).
  - Clears the step counter, carry register, operand shift registers, busy, done, s, cout and ovf to 0.
  - Applies at any time, including mid-RUN; the partial result is discarded.
- IDLE:
  - start=1 at edge E0 → latch a, b, cin; counter=0; state=RUN; busy=1 after E0.
- RUN:
  - At edge E(i+1), for i=0..N-1: add digit i (bits [i*STEP +: STEP], LSB digit first) plus the carry register.
  - Shift the STEP-bit digit sum into the result shift register; update the carry register.
  - The carry into the MSB is recorded on the final digit.
  - At edge EN: load s, cout and ovf; state=DONE.
- DONE:
  - busy=0 and done=1 for exactly one cycle (the cycle after EN).
  - Next edge → IDLE.
  - A start held high in DONE is not accepted until IDLE; earliest restart is edge EN+2.
- Latency: done is high in the cycle after the N-th edge following the accepting edge. Throughput is one result per N+2 cycles.
- start while busy=1 is ignored and does not disturb the operation.
- Changes on a, b or cin after the accepting edge have no effect.
- s, cout and ovf keep their previous values during RUN and change only at edge EN.
- Arithmetic is modulo 2^WIDTH; {cout,s} = a + b + cin exactly.

Optional Feature:
- Macro: ADD_SERIAL_SUB_EN.
- Defined:
  - Extra port sub (input, 1 bit), captured on the accepting edge.
  - sub=1 computes a - b as a + ~b + 1; cin is ignored.
  - cout=1 means no borrow; ovf is signed overflow of the subtraction.
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port; add only.

Test Plan:
1. WIDTH=8, STEP=1; a=0x35, b=0x4A, cin=0, start pulsed → s=0x7F, cout=0, ovf=0; done high exactly in the cycle after the 8th edge following the start edge; busy high for 8 cycles.
2. WIDTH=8, STEP=1; a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, ovf=0.
3. WIDTH=8, STEP=1; a=0x7F, b=0x01, cin=1 → s=0x81, cout=0, ovf=1.
4. WIDTH=8, STEP=4; a=0xA5, b=0x5B, cin=0 → s=0x00, cout=1, ovf=0; done in the cycle after the 2nd edge following start.
5. WIDTH=8, STEP=1:
   - Start 0x12+0x34. Re-pulse start with new operands at RUN cycle 2 → result still 0x46.
   - Next op: assert rst_n=0 at RUN cycle 3 → busy, done, s, cout and ovf all 0 immediately, no done pulse.
   - After release, start 0x01+0x01 → s=0x02.
6. ADD_SERIAL_SUB_EN defined; sub=1, a=0x10, b=0x20 → s=0xF0, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 → s=0x7F, cout=1, ovf=1.
